// File: rtl/cordic_pkg.sv
// Shared types and Q16-degree angle tables for the CORDIC angle sequencer.
// Table entries are round(angle_in_degrees * 2^16); entry 0 of the atanh table is unused.
package cordic_pkg;

    typedef enum logic {
        CIRC  = 1'b0,
        HYPER = 1'b1
    } mode_t;

    localparam int MAX_DEPTH = 32;
    localparam int ATAN_N    = 40;
    localparam int ATANH_N   = 41;

    localparam logic [5:0] HYP_REP_A = 6'd4;
    localparam logic [5:0] HYP_REP_B = 6'd13;
    localparam logic [5:0] HYP_REP_C = 6'd40;

    localparam logic [23:0] ATAN_Q16 [0:39] = '{
        24'd2949120, 24'd1740967, 24'd919879, 24'd466945, 24'd234379,
        24'd117304,  24'd58666,   24'd29335,  24'd14668,  24'd7334,
        24'd3667,    24'd1833,    24'd917,    24'd458,    24'd229,
        24'd115,     24'd57,      24'd29,     24'd14,     24'd7,
        24'd4,       24'd2,       24'd1,      24'd0,      24'd0,
        24'd0,       24'd0,       24'd0,      24'd0,      24'd0,
        24'd0,       24'd0,       24'd0,      24'd0,      24'd0,
        24'd0,       24'd0,       24'd0,      24'd0,      24'd0
    };

    localparam logic [23:0] ATANH_Q16 [0:40] = '{
        24'd0,       24'd2062610, 24'd959059, 24'd471835, 24'd234990,
        24'd117380,  24'd58676,   24'd29336,  24'd14668,  24'd7334,
        24'd3667,    24'd1833,    24'd917,    24'd458,    24'd229,
        24'd115,     24'd57,      24'd29,     24'd14,     24'd7,
        24'd4,       24'd2,       24'd1,      24'd0,      24'd0,
        24'd0,       24'd0,       24'd0,      24'd0,      24'd0,
        24'd0,       24'd0,       24'd0,      24'd0,      24'd0,
        24'd0,       24'd0,       24'd0,      24'd0,      24'd0,
        24'd0
    };

    function automatic logic is_hyp_repeat(input logic [5:0] s);
        return (s == HYP_REP_A) || (s == HYP_REP_B) || (s == HYP_REP_C);
    endfunction

endpackage

// File: rtl/cordic_angle_rom.sv
// Combinational elementary-angle lookup: (mode, shift) -> angle rounded to FRAC bits.
module cordic_angle_rom
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  mode_t              mode,
    input  logic [5:0]         shift,
    output logic [WIDTH-1:0]   angle
);

    localparam int          SH   = 16 - FRAC;
    localparam logic [24:0] HALF = (25'd1 << SH) >> 1;

    logic [23:0] q16;
    logic [24:0] rounded;

    always_comb begin
        q16 = '0;
        if (mode == CIRC) begin
            if (shift < 6'(ATAN_N)) q16 = ATAN_Q16[shift];
        end else begin
            if (shift < 6'(ATANH_N)) q16 = ATANH_Q16[shift];
        end
        // round-half-up before dropping the unused fraction bits
        rounded = ({1'b0, q16} + HALF) >> SH;
    end

    assign angle = WIDTH'(rounded);

endmodule

// File: rtl/cordic_angle_sequencer.sv
// Streams DEPTH beats of {index, shift, elementary angle} per start request.
module cordic_angle_sequencer
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [4:0]       idx_o,
    output logic [5:0]       shift_o,
    output logic [WIDTH-1:0] angle_o,
    output logic             last_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);

    state_t           state;
    mode_t            mode_q;
    logic             rep_q;
    mode_t            rom_mode;
    logic [5:0]       rom_shift;
    logic             next_rep;
    logic [4:0]       next_idx;
    logic [WIDTH-1:0] rom_angle;

    // ROM address is the beat about to be loaded: first beat in IDLE, following beat in RUN
    always_comb begin
        rom_mode  = CIRC;
        rom_shift = '0;
        next_rep  = 1'b0;
        next_idx  = idx_o + 5'd1;
        if (state == IDLE) begin
            rom_mode  = mode_t'(mode_i);
            rom_shift = mode_i ? 6'd1 : 6'd0;
        end else begin
            rom_mode  = mode_q;
            rom_shift = shift_o + 6'd1;
            if (mode_q == HYPER && is_hyp_repeat(shift_o) && !rep_q) begin
                rom_shift = shift_o;
                next_rep  = 1'b1;
            end
        end
    end

    cordic_angle_rom #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_rom (
        .mode  (rom_mode),
        .shift (rom_shift),
        .angle (rom_angle)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mode_q  <= CIRC;
            rep_q   <= 1'b0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            idx_o   <= '0;
            shift_o <= '0;
            angle_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state   <= RUN;
                        mode_q  <= mode_t'(mode_i);
                        rep_q   <= 1'b0;
                        valid_o <= 1'b1;
                        busy_o  <= 1'b1;
                        idx_o   <= '0;
                        shift_o <= rom_shift;
                        angle_o <= rom_angle;
                        last_o  <= (LAST_IDX == 5'd0);
                    end
                end
                RUN: begin
                    if (ready_i) begin
                        if (last_o) begin
                            state   <= IDLE;
                            valid_o <= 1'b0;
                            busy_o  <= 1'b0;
                            last_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else begin
                            idx_o   <= next_idx;
                            shift_o <= rom_shift;
                            angle_o <= rom_angle;
                            rep_q   <= next_rep;
                            last_o  <= (next_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Directed + randomized bench for cordic_angle_sequencer against a real-arithmetic angle model.
module tb_cordic_angle_sequencer;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, mode, ready, sel;

    logic        valid_a, last_a, busy_a, done_a;
    logic [4:0]  idx_a;
    logic [5:0]  shift_a;
    logic [31:0] angle_a;
    logic        valid_b, last_b, busy_b, done_b;
    logic [4:0]  idx_b;
    logic [5:0]  shift_b;
    logic [31:0] angle_b;

    cordic_angle_sequencer #(.WIDTH(32), .FRAC(8), .DEPTH(16)) dut_a (
        .clk(clk), .rst(rst), .start_i(start & ~sel), .mode_i(mode), .ready_i(ready),
        .valid_o(valid_a), .idx_o(idx_a), .shift_o(shift_a), .angle_o(angle_a),
        .last_o(last_a), .busy_o(busy_a), .done_o(done_a)
    );

    cordic_angle_sequencer #(.WIDTH(32), .FRAC(16), .DEPTH(32)) dut_b (
        .clk(clk), .rst(rst), .start_i(start & sel), .mode_i(mode), .ready_i(ready),
        .valid_o(valid_b), .idx_o(idx_b), .shift_o(shift_b), .angle_o(angle_b),
        .last_o(last_b), .busy_o(busy_b), .done_o(done_b)
    );

    logic        valid, last, busy, done;
    logic [4:0]  idx;
    logic [5:0]  shift;
    logic [31:0] angle;
    assign valid = sel ? valid_b : valid_a;
    assign last  = sel ? last_b  : last_a;
    assign busy  = sel ? busy_b  : busy_a;
    assign done  = sel ? done_b  : done_a;
    assign idx   = sel ? idx_b   : idx_a;
    assign shift = sel ? shift_b : shift_a;
    assign angle = sel ? angle_b : angle_a;

    int n_cmp = 0;
    int n_err = 0;
    int exp_sh  [32];
    int got_ang [32];
    int got_sh  [32];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Angle from first principles: degrees*2^16 rounded, then round-half-up to FRAC bits.
    function automatic logic [63:0] exp_angle(input bit md, input int s, input int frac);
        real    x, deg;
        longint q, r;
        if (!md && s >= 40) return 64'd0;
        if (md && (s >= 41 || s == 0)) return 64'd0;
        x   = $pow(2.0, -real'(s));
        deg = (md ? $atanh(x) : $atan(x)) * 180.0 / PI;
        q   = longint'($floor(deg * 65536.0 + 0.5));
        r   = (q + ((longint'(1) << (16 - frac)) >>> 1)) >>> (16 - frac);
        return 64'(r);
    endfunction

    // Expected shift list: circular counts up from 0; hyperbolic from 1 with 4/13/40 doubled.
    task automatic build_shifts(input bit md, input int depth);
        int s, n;
        s = md ? 1 : 0;
        n = 0;
        while (n < depth) begin
            exp_sh[n] = s;
            n++;
            if (md && (s == 4 || s == 13 || s == 40) && n < depth) begin
                exp_sh[n] = s;
                n++;
            end
            s++;
        end
    endtask

    task automatic check_beat(input int b, input bit md, input int frac, input int depth);
        check($sformatf("valid[%0d]", b), 64'(valid), 64'd1);
        check($sformatf("busy[%0d]", b), 64'(busy), 64'd1);
        check($sformatf("done_in_run[%0d]", b), 64'(done), 64'd0);
        check($sformatf("idx[%0d]", b), 64'(idx), 64'(b));
        check($sformatf("shift[%0d]", b), 64'(shift), 64'(exp_sh[b]));
        check($sformatf("angle[%0d]", b), 64'(angle), exp_angle(md, exp_sh[b], frac));
        check($sformatf("last[%0d]", b), 64'(last), 64'(b == depth - 1));
    endtask

    task automatic run_seq(input bit md, input int stall_at, input int stall_len,
                           input bit rnd, input bit poke);
        int depth, frac, extra, ncyc, stalls;
        depth  = sel ? 32 : 16;
        frac   = sel ? 16 : 8;
        stalls = 0;
        build_shifts(md, depth);
        start = 1'b1; mode = md; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ncyc  = 1;
        for (int b = 0; b < depth; b++) begin
            check_beat(b, md, frac, depth);
            got_ang[b] = int'(angle);
            got_sh[b]  = int'(shift);
            if (poke && b == 2) begin
                start = 1'b1;
                mode  = ~md;
            end
            extra = (b == stall_at) ? stall_len : 0;
            if (rnd) extra += int'($urandom_range(0, 2));
            if (extra > 0) begin
                ready = 1'b0;
                for (int k = 0; k < extra; k++) begin
                    @(negedge clk);
                    ncyc++;
                    start = 1'b0;
                    check_beat(b, md, frac, depth);
                end
                ready = 1'b1;
            end
            stalls += extra;
            @(negedge clk);
            ncyc++;
            start = 1'b0;
        end
        check("done_pulse", 64'(done), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("valid_after", 64'(valid), 64'd0);
        check("start_to_done", 64'(ncyc), 64'(depth + 1 + stalls));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(valid), 64'd0);
        check({tag, "_last"},  64'(last),  64'd0);
        check({tag, "_busy"},  64'(busy),  64'd0);
        check({tag, "_done"},  64'(done),  64'd0);
        check({tag, "_idx"},   64'(idx),   64'd0);
        check({tag, "_shift"}, 64'(shift), 64'd0);
        check({tag, "_angle"}, 64'(angle), 64'd0);
    endtask

    initial begin
        bit rmd;
        rst = 1'b1; start = 1'b0; mode = 1'b0; ready = 1'b1; sel = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // circular FRAC=8, known first four angles
        run_seq(1'b0, -1, 0, 1'b0, 1'b0);
        check("circ_a0", 64'(got_ang[0]), 64'd11520);
        check("circ_a1", 64'(got_ang[1]), 64'd6801);
        check("circ_a2", 64'(got_ang[2]), 64'd3593);
        check("circ_a3", 64'(got_ang[3]), 64'd1824);

        // hyperbolic started in the done cycle of the previous run
        run_seq(1'b1, -1, 0, 1'b0, 1'b0);
        check("hyp_a0", 64'(got_ang[0]), 64'd8057);
        check("hyp_s0", 64'(got_sh[0]), 64'd1);
        check("hyp_s3", 64'(got_sh[3]), 64'd4);
        check("hyp_s4", 64'(got_sh[4]), 64'd4);
        check("hyp_s15", 64'(got_sh[15]), 64'd14);

        // backpressure on beat 2, then start/mode poke during RUN
        run_seq(1'b0, 2, 3, 1'b0, 1'b0);
        run_seq(1'b1, -1, 0, 1'b0, 1'b1);
        run_seq(1'b0, -1, 0, 1'b0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            rmd = 1'($urandom_range(0, 1));
            run_seq(rmd, int'($urandom_range(0, 15)), int'($urandom_range(1, 3)), 1'b1, 1'b0);
        end

        // reset in the middle of a sequence
        start = 1'b1; mode = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_idx", 64'(idx), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midreset");
        @(negedge clk);
        check("idle_valid", 64'(valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        run_seq(1'b0, -1, 0, 1'b0, 1'b0);

        // FRAC=16, DEPTH=32: high shifts give zero angle but are still handshaked
        sel = 1'b1;
        @(negedge clk);
        run_seq(1'b0, -1, 0, 1'b1, 1'b0);
        check("b_circ_a24", 64'(got_ang[24]), 64'd0);
        check("b_circ_a31", 64'(got_ang[31]), 64'd0);
        check("b_circ_a0", 64'(got_ang[0]), 64'd2949120);
        run_seq(1'b1, 5, 2, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cordic_angle_sequencer.md
# cordic_angle_sequencer

Parametrised, sequential generator of CORDIC micro-rotation angles. On a start request it streams DEPTH beats of {iteration index, shift amount, elementary angle} over a valid/ready handshake. Angles are in fixed-point degrees with FRAC fractional bits. Circular mode gives atan(2^-s); hyperbolic mode gives atanh(2^-s) with the standard repeated iterations. It feeds the iterative CORDIC datapath, replacing the integer-degree angle table.

## Interface
- WIDTH, 32: angle word width; two's complement, unsigned values only in practice.
- FRAC, 16: fractional bits of angle_o in degrees; 1 ≤ FRAC ≤ 16, FRAC+7 ≤ WIDTH.
- DEPTH, 16: beats per sequence; 1 ≤ DEPTH ≤ 32.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  sequence request; sampled only in IDLE.
- mode_i  in  1  0 = circular, 1 = hyperbolic; latched with start_i.
- ready_i  in  1  consumer accepts the current beat.
- valid_o  out  1  beat valid.
- idx_o  out  5  beat number 0..DEPTH-1.
- shift_o  out  6  shift amount s for this beat.
- angle_o  out  WIDTH  elementary angle, rounded to FRAC bits.
- last_o  out  1  the current beat is beat DEPTH-1; qualified by valid_o.
- busy_o  out  1  high in RUN.
- done_o  out  1  single-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, RUN.
- IDLE → RUN when start_i=1. On entry: latch mode, idx=0. Initial shift is 0 in circular mode and 1 in hyperbolic mode. Clear the repeat flag.
- RUN: a beat transfers when valid_o && ready_i. On transfer:
  - idx increments.
  - In circular mode, shift increments.
  - In hyperbolic mode, shift increments, except that shift values 4, 13 and 40 are emitted twice. A repeat flag selects the second emission; shift advances on the second one.
- RUN → IDLE on transfer of beat DEPTH-1. done_o = 1 in the following cycle.
- Angle value: the Q16 degree constant for shift s, taken from the package table, then:
  - shifted right by 16-FRAC with round-half-up;
  - zero-extended to WIDTH.
  - Shifts beyond the table entries produce 0. A beat is still emitted.
- start_i in RUN is ignored; mode_i is not re-sampled.
- Backpressure: while valid_o && !ready_i, every output holds stable.
- Reset values, from any state including mid-sequence: state IDLE; valid_o, last_o, busy_o and done_o = 0; idx_o, shift_o and angle_o = 0.

## Timing
- All outputs are registered.
- start accepted at edge t → valid_o=1 with beat 0 from t+1.
- With ready_i held high, beats arrive on consecutive cycles, and beat k is presented in cycle t+1+k.
- Final transfer in cycle t+DEPTH → done_o=1 and busy_o=0 in cycle t+DEPTH+1.
- A start_i in that same cycle is accepted. Minimum start-to-start spacing is DEPTH+1 cycles.
- valid_o and busy_o are identical in RUN. done_o never coincides with valid_o.

## Structure
- Package cordic_pkg contains:
  - the mode type (CIRC, HYPER);
  - MAX_DEPTH = 32;
  - ATAN_Q16[0:39] and ATANH_Q16[0:40], both in degrees × 2^16, rounded;
  - the hyperbolic repeat-index constants 4, 13, 40.
- Sub-module cordic_angle_rom is combinational: (mode, shift) → rounded WIDTH-bit angle, parametrised by WIDTH and FRAC.
- The FSM, index/shift counters and output registers live in the top module.

## Test plan
- FRAC=8, circular, ready_i=1, start pulse → four beats:
  - shift 0, angle 11520;
  - shift 1, angle 6801;
  - shift 2, angle 3593;
  - shift 3, angle 1824.
  - last_o on beat 15, done_o one cycle later, 17 cycles from start to done.
- FRAC=8, hyperbolic, DEPTH=16 → shift sequence 1,2,3,4,4,5,…,13,13,14. Beat 0 angle 8057; beats 3 and 4 both carry the same atanh(1/16) value.
- Backpressure: ready_i low for 3 cycles on beat 2 → beat 2 held bit-stable, no beat skipped, total beats = DEPTH.
- start_i pulsed during RUN with mode_i flipped → ignored; sequence and mode unchanged.
- rst asserted at beat 5 → next cycle all outputs 0 and state IDLE. A subsequent start restarts from beat 0.
- start_i high in the done_o cycle → beat 0 appears the next cycle. With FRAC=16, high shifts (s ≥ 24, circular) emit angle 0 and are still handshaked.
